// File: rtl/demux_seq_pkg.sv
// Shared definitions for the demux channel sequencer: state encoding, sizes,
// DWELL limits and the enabled-channel search helper.
package demux_seq_pkg;

    localparam int NUM_CH    = 4;
    localparam int CH_W      = 2;
    localparam int CNT_W     = 8;
    localparam int DWELL_MIN = 1;
    localparam int DWELL_MAX = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2,
        FIN    = 2'd3
    } state_t;

    typedef struct packed {
        logic            found;
        logic [CH_W-1:0] ch;
    } ch_pick_t;

    // Lowest enabled channel at or above start; found=0 when none remains.
    function automatic ch_pick_t find_ch(input logic [NUM_CH-1:0] en,
                                         input logic [CH_W:0]     start);
        ch_pick_t p;
        p.found = 1'b0;
        p.ch    = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (c >= int'(start) && en[c]) begin
                p.found = 1'b1;
                p.ch    = CH_W'(c);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/demux_channel_sequencer_dwell_counter.sv
// Down-counter for the per-channel dwell time; saturates at zero.
module dwell_counter
    import demux_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] init,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= init;
        else if (en && cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/demux_channel_sequencer.sv
// Steps a latched 4-bit frame onto a 1:4 demux one channel at a time.
// Optional DEMUX_SEQ_MASK_EN adds a per-frame channel mask input M.
module demux_channel_sequencer
    import demux_seq_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] D,
    input  logic              V,
`ifdef DEMUX_SEQ_MASK_EN
    input  logic [NUM_CH-1:0] M,
`endif
    output logic              R,
    output logic              I,
    output logic [CH_W-1:0]   S,
    output logic              E,
    output logic              BUSY,
    output logic              DONE
);

    if (DWELL < DWELL_MIN || DWELL > DWELL_MAX) begin : g_dwell_range
        $error("DWELL out of range 1..255");
    end

    state_t            state;
    logic [NUM_CH-1:0] frame_q;
    logic [NUM_CH-1:0] mask_q;
    logic [NUM_CH-1:0] accept_mask;
    ch_pick_t          first;
    ch_pick_t          nxt;
    logic              accept;
    logic              cnt_load;
    logic              cnt_en;
    logic              cnt_zero;

`ifdef DEMUX_SEQ_MASK_EN
    assign accept_mask = M;
`else
    assign accept_mask = '1;
`endif

    assign accept = (state == IDLE) && V && R;
    assign first  = find_ch(accept_mask, '0);
    // S is stable through ACTIVE and GAP, so this is the upcoming channel in both.
    assign nxt    = find_ch(mask_q, {1'b0, S} + (CH_W+1)'(1));

    assign cnt_load = accept || (state == GAP);
    assign cnt_en   = (state == ACTIVE);

    dwell_counter u_dwell (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .en   (cnt_en),
        .init (CNT_W'(DWELL - 1)),
        .zero (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            frame_q <= '0;
            mask_q  <= '0;
            R       <= 1'b1;
            E       <= 1'b0;
            I       <= 1'b0;
            S       <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        frame_q <= D;
                        mask_q  <= accept_mask;
                        R       <= 1'b0;
                        BUSY    <= 1'b1;
                        if (first.found) begin
                            state <= ACTIVE;
                            E     <= 1'b1;
                            S     <= first.ch;
                            I     <= D[first.ch];
                        end else begin
                            state <= FIN;
                            DONE  <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (cnt_zero) begin
                        E <= 1'b0;
                        if (nxt.found) begin
                            state <= GAP;
                        end else begin
                            state <= FIN;
                            DONE  <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    state <= ACTIVE;
                    E     <= 1'b1;
                    S     <= nxt.ch;
                    I     <= frame_q[nxt.ch];
                end
                FIN: begin
                    state <= IDLE;
                    R     <= 1'b1;
                    BUSY  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_demux_channel_sequencer.sv
// Three sequencers (DWELL = 2, 1, 3) checked every cycle against a slot-schedule
// model, plus literal expectations for the directed scenarios.
module tb_demux_channel_sequencer;

    localparam int NL = 3;

    logic       clk;
    logic       rst_a [NL];
    logic [3:0] d     [NL];
    logic       v     [NL];
    logic [3:0] m     [NL];
    logic       r_o   [NL];
    logic       i_o   [NL];
    logic [1:0] s_o   [NL];
    logic       e_o   [NL];
    logic       busy_o[NL];
    logic       done_o[NL];

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_on = 0;

    function automatic int dw_of(int g);
        return (g == 0) ? 2 : (g == 1) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < NL; g++) begin : g_dut
        demux_channel_sequencer #(.DWELL(dw_of(g))) u_dut (
            .clk  (clk),
            .rst  (rst_a[g]),
            .D    (d[g]),
            .V    (v[g]),
`ifdef DEMUX_SEQ_MASK_EN
            .M    (m[g]),
`endif
            .R    (r_o[g]),
            .I    (i_o[g]),
            .S    (s_o[g]),
            .E    (e_o[g]),
            .BUSY (busy_o[g]),
            .DONE (done_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---- model: a frame is a list of enabled channels, each owning a slot of
    // DWELL enabled cycles plus one trailing cycle (GAP, or FIN for the last).
    typedef struct packed {
        logic       e;
        logic       done;
        logic       has_ch;
        logic [1:0] ch;
    } exp_t;

    function automatic int fin_k(int dw, logic [3:0] msk);
        int n = 0;
        for (int c = 0; c < 4; c++) if (msk[c]) n++;
        return (n == 0) ? 1 : n * (dw + 1);
    endfunction

    function automatic exp_t sched(int dw, logic [3:0] msk, int k);
        int   chs[4];
        int   n = 0;
        int   idx, pos;
        exp_t x;
        for (int c = 0; c < 4; c++) if (msk[c]) begin chs[n] = c; n++; end
        x = '0;
        if (k == fin_k(dw, msk)) begin
            x.done = 1'b1;
        end else begin
            idx      = (k - 1) / (dw + 1);
            pos      = (k - 1) % (dw + 1);
            x.e      = (pos < dw);
            x.has_ch = 1'b1;
            x.ch     = 2'(chs[idx]);
        end
        return x;
    endfunction

    function automatic logic [3:0] mask_of(int g);
`ifdef DEMUX_SEQ_MASK_EN
        return m[g];
`else
        return 4'hF;
`endif
    endfunction

    bit         in_frame[NL];
    int         k_m     [NL];
    logic [3:0] frm_m   [NL];
    logic [3:0] msk_m   [NL];
    logic [1:0] s_h     [NL];
    logic       i_h     [NL];

    always @(posedge clk) begin
        for (int g = 0; g < NL; g++) begin
            exp_t x;
            if (rst_a[g]) begin
                in_frame[g] = 0;
                k_m[g] = 0;
                s_h[g] = 2'd0;
                i_h[g] = 1'b0;
            end else if (!in_frame[g]) begin
                if (v[g]) begin
                    in_frame[g] = 1;
                    k_m[g] = 1;
                    frm_m[g] = d[g];
                    msk_m[g] = mask_of(g);
                end
            end else if (k_m[g] == fin_k(dw_of(g), msk_m[g])) begin
                in_frame[g] = 0;
            end else begin
                k_m[g]++;
            end
            if (in_frame[g]) begin
                x = sched(dw_of(g), msk_m[g], k_m[g]);
                if (x.has_ch) begin
                    s_h[g] = x.ch;
                    i_h[g] = frm_m[g][x.ch];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int g = 0; g < NL; g++) begin
                exp_t x;
                x = '0;
                if (in_frame[g]) x = sched(dw_of(g), msk_m[g], k_m[g]);
                chk($sformatf("l%0d.R", g),    int'(r_o[g]),    int'(!in_frame[g]));
                chk($sformatf("l%0d.BUSY", g), int'(busy_o[g]), int'(in_frame[g]));
                chk($sformatf("l%0d.E", g),    int'(e_o[g]),    int'(x.e));
                chk($sformatf("l%0d.DONE", g), int'(done_o[g]), int'(x.done));
                chk($sformatf("l%0d.S", g),    int'(s_o[g]),    int'(s_h[g]));
                chk($sformatf("l%0d.I", g),    int'(i_o[g]),    int'(i_h[g]));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int g = 0; g < NL; g++) begin
            rst_a[g] = 1'b1; d[g] = 4'h0; v[g] = 1'b1; m[g] = 4'hF;
        end
        tick(2);
        // V high together with rst must not start a frame
        for (int g = 0; g < NL; g++) begin
            chk($sformatf("rst.l%0d.R", g),    int'(r_o[g]),    1);
            chk($sformatf("rst.l%0d.E", g),    int'(e_o[g]),    0);
            chk($sformatf("rst.l%0d.S", g),    int'(s_o[g]),    0);
            chk($sformatf("rst.l%0d.I", g),    int'(i_o[g]),    0);
            chk($sformatf("rst.l%0d.BUSY", g), int'(busy_o[g]), 0);
            chk($sformatf("rst.l%0d.DONE", g), int'(done_o[g]), 0);
            rst_a[g] = 1'b0; v[g] = 1'b0;
        end
        cmp_on = 1;
        tick(2);

        // DWELL=2, D=1010; D rewritten mid-frame must not leak into I
        d[0] = 4'b1010; v[0] = 1'b1;
        tick();
        v[0] = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            if (k == 1)  begin chk("s1.k1.E", int'(e_o[0]), 1); chk("s1.k1.I", int'(i_o[0]), 0); end
            if (k == 3)  begin chk("s1.gap.E", int'(e_o[0]), 0); d[0] = 4'b0101; end
            if (k == 5)  begin chk("s1.k5.S", int'(s_o[0]), 1); chk("s1.k5.I", int'(i_o[0]), 1); end
            if (k == 11) begin chk("s1.k11.S", int'(s_o[0]), 3); chk("s1.k11.I", int'(i_o[0]), 1); end
            if (k == 12) chk("s1.k12.DONE", int'(done_o[0]), 1);
            if (k == 13) chk("s1.k13.R", int'(r_o[0]), 1);
            if (k < 13) tick();
        end

        // reset during channel 2 of a DWELL=2 frame
        d[0] = 4'b1111; v[0] = 1'b1;
        tick();
        v[0] = 1'b0;
        tick(6);
        chk("s3.pre.S", int'(s_o[0]), 2);
        chk("s3.pre.E", int'(e_o[0]), 1);
        rst_a[0] = 1'b1;
        tick();
        rst_a[0] = 1'b0;
        chk("s3.E", int'(e_o[0]), 0);
        chk("s3.S", int'(s_o[0]), 0);
        chk("s3.R", int'(r_o[0]), 1);
        chk("s3.BUSY", int'(busy_o[0]), 0);
        for (int k = 0; k < 12; k++) begin
            chk("s3.noDONE", int'(done_o[0]), 0);
            tick();
        end

        // DWELL=1 back-to-back with V held high
        d[1] = 4'b1111; v[1] = 1'b1;
        tick();
        d[1] = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            if (k == 1)  chk("s2.k1.I", int'(i_o[1]), 1);
            if (k == 7)  begin chk("s2.k7.S", int'(s_o[1]), 3); chk("s2.k7.I", int'(i_o[1]), 1); end
            if (k == 8)  chk("s2.k8.DONE", int'(done_o[1]), 1);
            if (k == 9)  chk("s2.k9.R", int'(r_o[1]), 1);
            if (k == 10) begin
                chk("s2.k10.E", int'(e_o[1]), 1);
                chk("s2.k10.I", int'(i_o[1]), 0);
                v[1] = 1'b0;
            end
            tick();
        end
        tick(10);

`ifdef DEMUX_SEQ_MASK_EN
        // DWELL=3 with M=1001
        d[2] = 4'b1001; m[2] = 4'b1001; v[2] = 1'b1;
        tick();
        v[2] = 1'b0; m[2] = 4'b1111;
        for (int k = 1; k <= 9; k++) begin
            if (k == 3) begin chk("s4.k3.E", int'(e_o[2]), 1); chk("s4.k3.S", int'(s_o[2]), 0); end
            if (k == 4) chk("s4.gap.E", int'(e_o[2]), 0);
            if (k == 5) begin chk("s4.k5.S", int'(s_o[2]), 3); chk("s4.k5.I", int'(i_o[2]), 1); end
            if (k == 7) chk("s4.k7.E", int'(e_o[2]), 1);
            if (k == 8) chk("s4.k8.DONE", int'(done_o[2]), 1);
            if (k == 9) chk("s4.k9.R", int'(r_o[2]), 1);
            tick();
        end
        // all-zero mask: straight to FIN
        m[2] = 4'b0000; d[2] = 4'b1111; v[2] = 1'b1;
        tick();
        v[2] = 1'b0; m[2] = 4'b1111;
        chk("s5.k1.DONE", int'(done_o[2]), 1);
        chk("s5.k1.E", int'(e_o[2]), 0);
        tick();
        chk("s5.k2.R", int'(r_o[2]), 1);
        chk("s5.k2.E", int'(e_o[2]), 0);
        tick(3);
`else
        // DWELL=3, D=0110, all channels
        d[2] = 4'b0110; v[2] = 1'b1;
        tick();
        v[2] = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            if (k == 9)  begin chk("s4.k9.S", int'(s_o[2]), 2); chk("s4.k9.I", int'(i_o[2]), 1); end
            if (k == 16) chk("s4.k16.DONE", int'(done_o[2]), 1);
            if (k == 17) chk("s4.k17.R", int'(r_o[2]), 1);
            tick();
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
